// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings and default widths.
package inst_fetch_queue_pkg;

   localparam int unsigned PC_W_DEF   = 16;
   localparam int unsigned INST_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 4;

   // Fetch FSM: IDLE waits for FIFO credit, REQ fetches, FLUSH drains a stale request
   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_REQ   = 2'd1,
      FS_FLUSH = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous prefetch FIFO holding {inst, pc} entries; clr empties it in one cycle.
module inst_fetch_queue_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   assign head = mem[rd_ptr];

   // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: IMEM req/ack fetch FSM, prefetch queue, redirect flush.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned INST_W = INST_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              sysCLK,
   input  logic              pRST,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_data,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_out,
   output logic [PC_W-1:0]   inst_pc,
   output logic [PC_W-1:0]   inst_pcnext
);

   localparam int unsigned ENT_W = INST_W + PC_W;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   fetch_state_e      state;
   fetch_state_e      state_nx;
   logic [PC_W-1:0]   fetch_pc;
   logic [PC_W-1:0]   fetch_pc_nx;
   logic [PC_W-1:0]   addr_nx;
   logic              ack_ok;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_after;
   logic              credit;
   logic [ENT_W-1:0]  head;

   // imem_req doubles as the outstanding flag; acks without a request are ignored
   assign ack_ok      = imem_ack & imem_req;
   assign push        = ack_ok & (state == FS_REQ) & ~redirect;
   assign pop         = inst_valid & inst_ready & ~redirect;
   assign count_after = count + CNT_W'(push) - CNT_W'(pop);
   assign credit      = (count_after < CNT_W'(DEPTH));

   // Next-state, next fetch PC and next request address; redirect overrides everything
   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      addr_nx     = imem_addr;
      if (redirect) begin
         fetch_pc_nx = redirect_pc;
         if (state == FS_IDLE || ack_ok) begin
            state_nx = FS_REQ;
            addr_nx  = redirect_pc;
         end else begin
            state_nx = FS_FLUSH;
         end
      end else begin
         case (state)
            FS_IDLE: begin
               if (credit) begin
                  state_nx = FS_REQ;
                  addr_nx  = fetch_pc;
               end
            end
            FS_REQ: begin
               if (ack_ok) begin
                  fetch_pc_nx = fetch_pc + PC_W'(1);
                  addr_nx     = fetch_pc + PC_W'(1);
                  state_nx    = credit ? FS_REQ : FS_IDLE;
               end
            end
            FS_FLUSH: begin
               if (ack_ok) begin
                  state_nx = FS_REQ;
                  addr_nx  = fetch_pc;
               end
            end
            default: begin
               state_nx = FS_IDLE;
            end
         endcase
      end
   end

   // FSM state, fetch PC and registered IMEM request outputs
   always_ff @(posedge sysCLK or posedge pRST) begin
      if (pRST) begin
         state     <= FS_IDLE;
         fetch_pc  <= '0;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         state     <= state_nx;
         fetch_pc  <= fetch_pc_nx;
         imem_req  <= (state_nx != FS_IDLE);
         imem_addr <= addr_nx;
      end
   end

   inst_fetch_queue_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (sysCLK),
      .rst   (pRST),
      .clr   (redirect),
      .push  (push),
      .pop   (pop),
      .din   ({imem_data, fetch_pc}),
      .head  (head),
      .count (count)
   );

   assign inst_valid  = (count != '0);
   assign inst_out    = head[ENT_W-1:PC_W];
   assign inst_pc     = head[PC_W-1:0];
   assign inst_pcnext = inst_pc + PC_W'(1);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with a configurable IMEM model.
module tb_inst_fetch_queue;

   typedef struct packed {
      logic [31:0] inst;
      logic [15:0] pc;
      logic [15:0] pcn;
   } exp_t;

   logic        sysCLK = 1'b0;
   logic        pRST;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [15:0] inst_pc;
   logic [15:0] inst_pcnext;

   // IMEM model controls
   logic zw;
   logic dly;
   logic man_ack;
   int   lat;
   int   wcnt;

   int   errors = 0;
   int   checks = 0;
   int   acc    = 0;
   exp_t exp_q[$];

   always #5 sysCLK = ~sysCLK;

   inst_fetch_queue dut (
      .sysCLK      (sysCLK),
      .pRST        (pRST),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .inst_pcnext (inst_pcnext)
   );

   assign imem_ack  = (zw & imem_req) | (dly & imem_req & (wcnt == lat)) | man_ack;
   assign imem_data = 32'h1000_0000 | {16'h0000, imem_addr};

   always @(posedge sysCLK) begin
      if (!imem_req || imem_ack) wcnt <= 0;
      else                       wcnt <= wcnt + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic step();
      @(posedge sysCLK);
      #1;
   endtask

   task automatic exp_push(input logic [15:0] pc, input logic [15:0] pcn);
      exp_t e;
      e.inst = 32'h1000_0000 | {16'h0000, pc};
      e.pc   = pc;
      e.pcn  = pcn;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      pRST = 1'b1;
      step();
      step();
      pRST = 1'b0;
   endtask

   task automatic wait_acc(input int target, input string nm);
      int n = 0;
      while (acc < target && n < 60) begin
         step();
         n++;
      end
      chk(nm, 64'(acc >= target), 64'd1);
   endtask

   // Monitor: every accepted head entry is compared against the scoreboard
   always @(negedge sysCLK) begin
      if (!pRST && inst_valid && inst_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got pc %0h expected none", inst_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("inst_out", 64'(inst_out), 64'(e.inst));
            chk("inst_pc", 64'(inst_pc), 64'(e.pc));
            chk("inst_pcnext", 64'(inst_pcnext), 64'(e.pcn));
         end
         acc++;
      end
   end

   initial begin
      int n;
      int base;
      pRST = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      zw = 1'b0; dly = 1'b0; man_ack = 1'b0; lat = 0;

      // Reset values
      @(negedge sysCLK);
      chk("rst_imem_req", 64'(imem_req), 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst_out", 64'(inst_out), 64'd0);
      chk("rst_inst_pc", 64'(inst_pc), 64'd0);
      chk("rst_inst_pcnext", 64'(inst_pcnext), 64'd1);

      // 1) zero-wait streaming, one instruction per cycle
      zw = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_push(16'(i), 16'(i + 1));
      step();
      pRST = 1'b0;
      n = 0;
      while (acc < 8 && n < 40) begin
         step();
         n++;
      end
      inst_ready = 1'b0;
      chk("t1_cycles_to_8", 64'(n), 64'd10);
      chk("t1_queue_drained", 64'(exp_q.size()), 64'd0);

      // 2) back-pressure: exactly 4 queued, fetch stops, then drains and resumes at 4
      do_reset();
      for (int i = 0; i < 12; i++) step();
      @(negedge sysCLK);
      chk("t2_req_stopped", 64'(imem_req), 64'd0);
      chk("t2_next_addr", 64'(imem_addr), 64'd4);
      chk("t2_valid", 64'(inst_valid), 64'd1);
      chk("t2_head_pc", 64'(inst_pc), 64'd0);
      for (int i = 0; i < 8; i++) exp_push(16'(i), 16'(i + 1));
      base = acc;
      step();
      inst_ready = 1'b1;
      wait_acc(base + 8, "t2_drain_timeout");
      inst_ready = 1'b0;
      chk("t2_queue_drained", 64'(exp_q.size()), 64'd0);

      // 3) late IMEM, redirect to 0x40 during the wait
      zw = 1'b0; dly = 1'b1; lat = 3; inst_ready = 1'b1;
      do_reset();
      step();
      step();
      redirect = 1'b1; redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      @(negedge sysCLK);
      chk("t3_flush_req", 64'(imem_req), 64'd1);
      chk("t3_flush_addr_held", 64'(imem_addr), 64'd0);
      chk("t3_valid_after_redirect", 64'(inst_valid), 64'd0);
      step();
      step();
      @(negedge sysCLK);
      chk("t3_new_addr", 64'(imem_addr), 64'h0040);
      chk("t3_new_req", 64'(imem_req), 64'd1);
      exp_push(16'h0040, 16'h0041);
      base = acc;
      wait_acc(base + 1, "t3_first_timeout");
      inst_ready = 1'b0;

      // 4) redirect coinciding with ack and pop
      zw = 1'b1; dly = 1'b0;
      do_reset();
      step();
      step();
      step();
      inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
      step();
      redirect = 1'b0; inst_ready = 1'b0;
      @(negedge sysCLK);
      chk("t4_valid_cleared", 64'(inst_valid), 64'd0);
      chk("t4_addr", 64'(imem_addr), 64'h0100);
      chk("t4_req", 64'(imem_req), 64'd1);
      step();
      exp_push(16'h0100, 16'h0101);
      base = acc;
      inst_ready = 1'b1;
      wait_acc(base + 1, "t4_first_timeout");
      inst_ready = 1'b0;

      // 5) PC wrap through 0xFFFF
      do_reset();
      step();
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      step();
      redirect = 1'b0;
      exp_push(16'hFFFE, 16'hFFFF);
      exp_push(16'hFFFF, 16'h0000);
      exp_push(16'h0000, 16'h0001);
      exp_push(16'h0001, 16'h0002);
      base = acc;
      inst_ready = 1'b1;
      @(negedge sysCLK);
      chk("t5_valid_after_redirect", 64'(inst_valid), 64'd0);
      wait_acc(base + 4, "t5_wrap_timeout");
      inst_ready = 1'b0;

      // 6) reset mid-wait with 2 queued entries, stale ack afterwards
      do_reset();
      step();
      step();
      step();
      zw = 1'b0; dly = 1'b1; lat = 10;
      step();
      @(negedge sysCLK);
      chk("t6_pre_valid", 64'(inst_valid), 64'd1);
      chk("t6_pre_req", 64'(imem_req), 64'd1);
      pRST = 1'b1;
      #1;
      chk("t6_async_valid", 64'(inst_valid), 64'd0);
      chk("t6_async_req", 64'(imem_req), 64'd0);
      step();
      pRST = 1'b0; man_ack = 1'b1;
      step();
      man_ack = 1'b0; dly = 1'b0; zw = 1'b1;
      exp_push(16'h0000, 16'h0001);
      exp_push(16'h0001, 16'h0002);
      base = acc;
      inst_ready = 1'b1;
      @(negedge sysCLK);
      chk("t6_restart_req", 64'(imem_req), 64'd1);
      chk("t6_restart_addr", 64'(imem_addr), 64'd0);
      chk("t6_stale_not_queued", 64'(inst_valid), 64'd0);
      wait_acc(base + 2, "t6_restart_timeout");
      inst_ready = 1'b0;
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
